// File: rtl/sram_ctrl.sv
// Single-word read/write sequencer for a 1K x 8 asynchronous SRAM.
// Setup, write-pulse and read-access times are set by parameters; every SRAM pin is driven from a flop.
module sram_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int WR_SETUP = 1,
    parameter int WE_PULSE = 1,
    parameter int RD_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_done,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int MAX_A = (WR_SETUP > WE_PULSE) ? WR_SETUP : WE_PULSE;
    localparam int MAX_P = (MAX_A > RD_WAIT) ? MAX_A : RD_WAIT;
    localparam int CNT_W = $clog2(MAX_P + 1);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_WAIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               drive_en;
    logic [DATA_W-1:0]  wdata_q;

    // drive_en and sram_oe_n come from the same state flop, so they can never overlap.
    assign sram_data = drive_en ? wdata_q : 'z;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            drive_en  <= 1'b0;
            wdata_q   <= '0;
            sram_addr <= '0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        sram_addr <= req_addr;
                        req_ready <= 1'b0;
                        if (req_we) begin
                            wdata_q  <= req_wdata;
                            drive_en <= 1'b1;
                            cnt      <= CNT_W'(WR_SETUP - 1);
                            state    <= W_SETUP;
                        end else begin
                            sram_oe_n <= 1'b0;
                            cnt       <= CNT_W'(RD_WAIT - 1);
                            state     <= R_WAIT;
                        end
                    end
                end
                W_SETUP: begin
                    if (cnt == '0) begin
                        sram_we_n <= 1'b0;
                        cnt       <= CNT_W'(WE_PULSE - 1);
                        state     <= W_PULSE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                W_PULSE: begin
                    if (cnt == '0) begin
                        sram_we_n <= 1'b1;
                        state     <= W_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                W_HOLD: begin
                    drive_en  <= 1'b0;
                    wr_done   <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                R_WAIT: begin
                    if (cnt == '0) begin
                        rsp_rdata <= sram_data;
                        rsp_valid <= 1'b1;
                        sram_oe_n <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    drive_en  <= 1'b0;
                    sram_we_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default-timing and stretched-timing instances, each with its own SRAM model.
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_valid [2];
    logic       req_we    [2];
    logic [9:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic       wr_done   [2];
    logic       oe_n      [2];
    logic       we_n      [2];
    logic [7:0] rsp_rdata [2];
    logic [9:0] saddr     [2];
    wire  [7:0] sd0;
    wire  [7:0] sd1;

    logic [7:0] mem0 [1024];
    logic [7:0] mem1 [1024];

    int checks  = 0;
    int errors  = 0;
    int hazards = 0;

    sram_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .wr_done(wr_done[0]),
        .sram_addr(saddr[0]), .sram_data(sd0), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0])
    );

    sram_ctrl #(.WR_SETUP(3), .WE_PULSE(2), .RD_WAIT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .wr_done(wr_done[1]),
        .sram_addr(saddr[1]), .sram_data(sd1), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1])
    );

    // Asynchronous SRAM models: drive on oe_n low, capture on we_n falling edge.
    assign sd0 = (!oe_n[0] && we_n[0]) ? mem0[saddr[0]] : 8'bz;
    assign sd1 = (!oe_n[1] && we_n[1]) ? mem1[saddr[1]] : 8'bz;
    always @(negedge we_n[0]) mem0[saddr[0]] <= sd0;
    always @(negedge we_n[1]) mem1[saddr[1]] <= sd1;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!oe_n[d] && !we_n[d]) hazards++;
            if (rsp_valid[d] && wr_done[d]) hazards++;
            if ((rsp_valid[d] || wr_done[d]) && !req_ready[d]) hazards++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction; first/last are the cycles the strobe (we_n or oe_n) is low.
    task automatic xfer(input string tag, input int d, input bit we, input logic [9:0] a,
                        input logic [7:0] wd, input int e_first, input int e_last,
                        input int e_done, input logic [7:0] e_rd);
        int first = -1;
        int last  = -1;
        int done  = -1;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        check({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 40 && done < 0; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[d] = 1'b0;
            if (we ? !we_n[d] : !oe_n[d]) begin
                if (first < 0) first = c;
                last = c;
            end
            if (we ? wr_done[d] : rsp_valid[d]) begin
                done = c;
                if (!we) check({tag, "_rdata"}, 32'(rsp_rdata[d]), 32'(e_rd));
            end
        end
        check({tag, "_first"}, 32'(first), 32'(e_first));
        check({tag, "_last"},  32'(last),  32'(e_last));
        check({tag, "_done"},  32'(done),  32'(e_done));
    endtask

    bit         bw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [9:0] ba [4] = '{10'h000, 10'h000, 10'h3FF, 10'h3FF};
    logic [7:0] bd [4] = '{8'h11, 8'h00, 8'h22, 8'h00};
    logic [7:0] got [2];
    int         rc  [2];
    int         idx;
    int         nrsp;
    bit         pend;
    bit         flag;

    initial begin
        for (int k = 0; k < 1024; k++) begin
            mem0[k] = 8'h00;
            mem1[k] = 8'h00;
        end
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1;
            req_we[d]    = 1'b1;
            req_addr[d]  = 10'h155;
            req_wdata[d] = 8'hA5;
        end

        repeat (3) begin
            @(negedge clk);
            check("rst_we_n",   32'(we_n[0]),      32'd1);
            check("rst_oe_n",   32'(oe_n[0]),      32'd1);
            check("rst_rsp",    32'(rsp_valid[0]), 32'd0);
            check("rst_wrdone", 32'(wr_done[0]),   32'd0);
            check("rst_we_n1",  32'(we_n[1]),      32'd1);
        end
        rst_n        = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("rst_ready",  32'(req_ready[0]), 32'd1);
        check("rst_ready1", 32'(req_ready[1]), 32'd1);
        check("rst_addr",   32'(saddr[0]),     32'd0);
        check("rst_rdata",  32'(rsp_rdata[0]), 32'd0);
        check("rst_nowr",   32'(mem0[10'h155]), 32'd0);

        xfer("wr1", 0, 1'b1, 10'h155, 8'hA5, 2, 2, 4, 8'h00);
        xfer("rd1", 0, 1'b0, 10'h155, 8'h00, 1, 2, 3, 8'hA5);

        xfer("pwr", 1, 1'b1, 10'h0AA, 8'h5C, 4, 5, 7, 8'h00);
        xfer("prd", 1, 1'b0, 10'h0AA, 8'h00, 1, 4, 5, 8'h5C);

        // Back-to-back with req_valid held high; item 0 accepted at cycle 0.
        idx  = 0;
        nrsp = 0;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = bw[0];
        req_addr[0]  = ba[0];
        req_wdata[0] = bd[0];
        pend = req_ready[0];
        for (int c = 1; c <= 60 && nrsp < 2; c++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                got[nrsp] = rsp_rdata[0];
                rc[nrsp]  = c;
                nrsp++;
            end
            if (pend) begin
                idx++;
                if (idx < 4) begin
                    req_we[0]    = bw[idx];
                    req_addr[0]  = ba[idx];
                    req_wdata[0] = bd[idx];
                end else begin
                    req_valid[0] = 1'b0;
                end
            end
            pend = req_valid[0] && req_ready[0];
        end
        req_valid[0] = 1'b0;
        check("b2b_nrsp",  32'(nrsp),   32'd2);
        check("b2b_rd0",   32'(got[0]), 32'h11);
        check("b2b_rd1",   32'(got[1]), 32'h22);
        check("b2b_cyc0",  32'(rc[0]),  32'd7);
        check("b2b_cyc1",  32'(rc[1]),  32'd14);

        xfer("ext_w3ff", 0, 1'b1, 10'h3FF, 8'h00, 2, 2, 4, 8'h00);
        xfer("ext_w000", 0, 1'b1, 10'h000, 8'hFF, 2, 2, 4, 8'h00);
        xfer("ext_r3ff", 0, 1'b0, 10'h3FF, 8'h00, 1, 2, 3, 8'h00);
        xfer("ext_r000", 0, 1'b0, 10'h000, 8'h00, 1, 2, 3, 8'hFF);
        xfer("ext_w155", 0, 1'b1, 10'h155, 8'h3C, 2, 2, 4, 8'h00);
        check("ext_hold", 32'(rsp_rdata[0]), 32'hFF);

        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 10'h155;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("mid_oe_low", 32'(oe_n[0]), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_oe_n",  32'(oe_n[0]),      32'd1);
        check("mid_rdata", 32'(rsp_rdata[0]), 32'd0);
        check("mid_rsp",   32'(rsp_valid[0]), 32'd0);
        check("mid_ready", 32'(req_ready[0]), 32'd1);
        rst_n = 1'b1;
        flag  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid[0]) flag = 1'b1;
        end
        check("mid_norsp", 32'(flag), 32'd0);
        xfer("mid_rd", 0, 1'b0, 10'h155, 8'h00, 1, 2, 3, 8'h3C);

        check("hazards", 32'(hazards), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous controller that sits directly upstream of the 1K x 8 asynchronous SRAM (10-bit address, shared 8-bit tristate data bus, active-low oe_n/we_n, write captured on the falling edge of we_n). It accepts single-word read/write requests over a valid/ready handshake and sequences the SRAM pins with programmable setup, pulse and access times. Read data is returned on a one-cycle response strobe. All SRAM-side outputs come from flops, so the pins never glitch.

## Interface
- ADDR_W, 10, address width (matches SRAM depth 1024)
- DATA_W, 8, data width
- WR_SETUP, 1, cycles addr/data are stable with we_n high before we_n falls (>=1)
- WE_PULSE, 1, cycles we_n is held low (>=1)
- RD_WAIT, 2, cycles oe_n is low before read data is sampled (>=1)

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse: rsp_rdata is valid
- rsp_rdata  out  DATA_W  last read data; held until the next read completes
- wr_done  out  1  one-cycle pulse: write sequence finished
- sram_addr  out  ADDR_W  SRAM address pins
- sram_data  inout  DATA_W  SRAM data bus; driven only during write states, else high-Z
- sram_oe_n  out  1  SRAM output enable, active low
- sram_we_n  out  1  SRAM write enable, active low

## Operation
- Handshake: transfer occurs on a rising edge with req_valid && req_ready. req_addr, req_wdata and req_we are registered at that edge. The request inputs are don't-care otherwise.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT. A down-counter of width $clog2(max param + 1) times each state.
- IDLE: req_ready=1, we_n=1, oe_n=1, bus high-Z. An accepted write goes to W_SETUP. An accepted read goes to R_WAIT.
- W_SETUP (WR_SETUP cycles): sram_addr and data driven, we_n=1, oe_n=1, then go to W_PULSE.
- W_PULSE (WE_PULSE cycles): we_n=0, addr and data unchanged, then go to W_HOLD.
- W_HOLD (1 cycle): we_n=1, addr and data still driven. Then go to IDLE and pulse wr_done for 1 cycle.
- R_WAIT (RD_WAIT cycles): oe_n=0, bus high-Z, sram_addr stable. At the edge ending the last cycle, sram_data is registered into rsp_rdata. Then go to IDLE and pulse rsp_valid for 1 cycle.
- Bus safety: the data driver enable and oe_n=0 are never active in the same cycle. Both are registered from the same state, so a read accepted right after a write needs no extra turnaround.
- sram_addr holds its last value in IDLE.
- rsp_valid and wr_done are mutually exclusive. Both coincide with req_ready=1, so the next request can be accepted in that same cycle.
- Reset (rst_n low at any edge, including mid-sequence): next state is IDLE, the counter is cleared, and any in-flight request is dropped without a response.
- Reset values: sram_we_n=1, sram_oe_n=1, bus high-Z, sram_addr=0, rsp_valid=0, wr_done=0, rsp_rdata=0, req_ready=1 (from the first cycle after reset).
- A write aborted after we_n fell may already have stored data in the SRAM; this is accepted.

## Timing
- Accept edge = cycle 0.
- Write: setup occupies cycles 1..WR_SETUP; we_n is low for cycles WR_SETUP+1..WR_SETUP+WE_PULSE; hold is the next cycle. wr_done and req_ready are high at cycle WR_SETUP+WE_PULSE+2 (defaults: we_n low in cycle 2, wr_done in cycle 4).
- Read: oe_n is low for cycles 1..RD_WAIT; rsp_valid is high at cycle RD_WAIT+1 (default cycle 3).
- Throughput: one write per WR_SETUP+WE_PULSE+2 cycles; one read per RD_WAIT+1 cycles.
- The falling edge of we_n always follows at least WR_SETUP full cycles of stable addr and data.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> we_n=1, oe_n=1, bus Z, rsp_valid=0, no SRAM access; req_ready=1 after release.
- Single write then read: write addr 0x155 data 0xA5, then read 0x155 -> we_n low exactly cycle 2, wr_done cycle 4; rsp_valid 3 cycles after read accept with rsp_rdata=0xA5.
- Back-to-back: req_valid held high with W(0x000,0x11), R(0x000), W(0x3FF,0x22), R(0x3FF) -> reads return 0x11, 0x22; no cycle has driver enabled with oe_n=0.
- Parameters WR_SETUP=3, WE_PULSE=2, RD_WAIT=4 -> we_n low cycles 4..5, wr_done cycle 7; rsp_valid cycle 5 after read accept.
- Reset mid-read at cycle 1 of R_WAIT -> no rsp_valid, rsp_rdata=0, oe_n=1 after that edge, next request is accepted normally.
- Address wrap and extremes: write 0x00 to 0x3FF and 0xFF to 0x000, read both back -> data correct; rsp_rdata holds 0xFF through the following write.
